// File: rtl/wb_gpio_ctrl_if.sv
// Wishbone slave bus bundle for wb_gpio_ctrl. The signals keep the classic wbs_* pin names,
// so the _i/_o suffixes are seen from the slave side.
interface wb_gpio_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_gpio_ctrl.sv
// Wishbone GPIO controller: output/enable registers, synchronised inputs and per-pin edge
// interrupts with W1C status and a level irq output.
module wb_gpio_ctrl #(
    parameter int          NUM_IO      = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_gpio_ctrl_if.slave     wbs,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    output logic              irq_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACK   = 1'b1;

    localparam logic [7:0] OFS_DOUT = 8'h00;
    localparam logic [7:0] OFS_OEB  = 8'h04;
    localparam logic [7:0] OFS_DIN  = 8'h08;
    localparam logic [7:0] OFS_EN   = 8'h0C;
    localparam logic [7:0] OFS_STAT = 8'h10;
    localparam logic [7:0] OFS_ESEL = 8'h14;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel_v);
        logic [31:0] m_v;
        m_v = 32'h0;
        for (int b = 0; b < 4; b++) begin
            m_v[8*b +: 8] = {8{sel_v[b]}};
        end
        return m_v;
    endfunction

    function automatic logic [31:0] widen(input logic [NUM_IO-1:0] v);
        logic [31:0] w_v;
        w_v = 32'h0;
        w_v[NUM_IO-1:0] = v;
        return w_v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [31:0] mask_v);
        return (old_v & ~mask_v) | (new_v & mask_v);
    endfunction

    logic              state_r;
    logic              ack_r;
    logic [31:0]       dat_r;
    logic              irq_r;
    logic [NUM_IO-1:0] dout_r, oeb_r, en_r, stat_r, esel_r, prev_r;
    logic [NUM_IO-1:0] sync_r [SYNC_STAGES];

    logic              sel_s, commit_s, wr_s;
    logic [7:0]        ofs_s;
    logic [31:0]       bmask_s, rd_data_s, clr_wide_s;
    logic [31:0]       dout_wr_s, oeb_wr_s, en_wr_s, esel_wr_s;
    logic [NUM_IO-1:0] din_s, edge_hit_s, clr_s;

    assign sel_s      = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign ofs_s      = wbs.wbs_adr_i[7:0];
    assign commit_s   = sel_s & (state_r == ST_IDLE);
    assign wr_s       = commit_s & wbs.wbs_we_i;
    assign bmask_s    = byte_mask(wbs.wbs_sel_i);
    assign dout_wr_s  = merge(widen(dout_r), wbs.wbs_dat_i, bmask_s);
    assign oeb_wr_s   = merge(widen(oeb_r),  wbs.wbs_dat_i, bmask_s);
    assign en_wr_s    = merge(widen(en_r),   wbs.wbs_dat_i, bmask_s);
    assign esel_wr_s  = merge(widen(esel_r), wbs.wbs_dat_i, bmask_s);
    assign clr_wide_s = wbs.wbs_dat_i & bmask_s;

    // The edge detector looks at the last sync stage against one extra delayed copy.
    assign din_s      = sync_r[SYNC_STAGES-1];
    assign edge_hit_s = (din_s & ~prev_r & ~esel_r) | (~din_s & prev_r & esel_r);

    // W1C clear mask, only during a committed write to the status register
    always_comb begin
        clr_s = {NUM_IO{1'b0}};
        if (wr_s && (ofs_s == OFS_STAT)) begin
            clr_s = clr_wide_s[NUM_IO-1:0];
        end else begin
            clr_s = {NUM_IO{1'b0}};
        end
    end

    // Read mux; unmapped offsets return zero
    always_comb begin
        rd_data_s = 32'h0;
        case (ofs_s)
            OFS_DOUT: rd_data_s = widen(dout_r);
            OFS_OEB:  rd_data_s = widen(oeb_r);
            OFS_DIN:  rd_data_s = widen(din_s);
            OFS_EN:   rd_data_s = widen(en_r);
            OFS_STAT: rd_data_s = widen(stat_r);
            OFS_ESEL: rd_data_s = widen(esel_r);
            default:  rd_data_s = 32'h0;
        endcase
    end

    // Ack FSM: one-cycle ack, then a mandatory idle cycle before the next request
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
            ack_r   <= 1'b0;
            dat_r   <= 32'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sel_s) begin
                        state_r <= ST_ACK;
                        ack_r   <= 1'b1;
                        dat_r   <= rd_data_s;
                    end else begin
                        state_r <= ST_IDLE;
                        ack_r   <= 1'b0;
                        dat_r   <= 32'h0;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    dat_r   <= 32'h0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    dat_r   <= 32'h0;
                end
            endcase
        end
    end

    // Control registers; an edge in the same cycle as a W1C keeps the status bit set
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            dout_r <= {NUM_IO{1'b0}};
            oeb_r  <= {NUM_IO{1'b1}};
            en_r   <= {NUM_IO{1'b0}};
            esel_r <= {NUM_IO{1'b0}};
            stat_r <= {NUM_IO{1'b0}};
            irq_r  <= 1'b0;
        end else begin
            if (wr_s) begin
                case (ofs_s)
                    OFS_DOUT: dout_r <= dout_wr_s[NUM_IO-1:0];
                    OFS_OEB:  oeb_r  <= oeb_wr_s[NUM_IO-1:0];
                    OFS_EN:   en_r   <= en_wr_s[NUM_IO-1:0];
                    OFS_ESEL: esel_r <= esel_wr_s[NUM_IO-1:0];
                    default: begin
                    end
                endcase
            end
            stat_r <= (stat_r & ~clr_s) | edge_hit_s;
            irq_r  <= |(stat_r & en_r);
        end
    end

    // Input synchroniser and edge-history flops
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {NUM_IO{1'b0}};
            end
            prev_r <= {NUM_IO{1'b0}};
        end else begin
            sync_r[0] <= io_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= din_s;
        end
    end

    assign wbs.wbs_ack_o = ack_r;
    assign wbs.wbs_dat_o = dat_r;
    assign io_out        = dout_r;
    assign io_oeb        = oeb_r;
    assign irq_o         = irq_r;

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Self-checking bench for wb_gpio_ctrl: directed scenarios plus randomized register traffic
// compared against a register-level reference model.
module tb_wb_gpio_ctrl;
    localparam int          SYNC = 2;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_in, io_out, io_oeb;
    logic        irq;
    logic [7:0]  io_in8, io_out8, io_oeb8;
    logic        irq8;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_dout, m_oeb, m_en, m_stat, m_esel;

    always #5 clk = ~clk;

    wb_gpio_ctrl_if bus ();
    wb_gpio_ctrl_if bus8 ();

    wb_gpio_ctrl #(.NUM_IO(32), .BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus.slave),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq_o(irq));

    wb_gpio_ctrl #(.NUM_IO(8), .BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus8.slave),
        .io_in(io_in8), .io_out(io_out8), .io_oeb(io_oeb8), .irq_o(irq8));

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_dout = 32'h0; m_oeb = 32'hFFFF_FFFF; m_en = 32'h0; m_stat = 32'h0; m_esel = 32'h0;
    endfunction

    function automatic logic [31:0] ev_bits(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [31:0] esel_v);
        return (new_v & ~old_v & ~esel_v) | (~new_v & old_v & esel_v);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] ofs);
        case (ofs)
            8'h00:   return m_dout;
            8'h04:   return m_oeb;
            8'h08:   return io_in;
            8'h0C:   return m_en;
            8'h10:   return m_stat;
            8'h14:   return m_esel;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_write(input logic [7:0] ofs, input logic [3:0] sel, input logic [31:0] d);
        logic [31:0] mk;
        mk = 32'h0;
        for (int b = 0; b < 4; b++) mk[8*b +: 8] = {8{sel[b]}};
        case (ofs)
            8'h00:   m_dout = (m_dout & ~mk) | (d & mk);
            8'h04:   m_oeb  = (m_oeb  & ~mk) | (d & mk);
            8'h0C:   m_en   = (m_en   & ~mk) | (d & mk);
            8'h10:   m_stat = m_stat & ~(d & mk);
            8'h14:   m_esel = (m_esel & ~mk) | (d & mk);
            default: ;
        endcase
    endfunction

    // ---------------- bus helpers (no checking inside) ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        repeat (SYNC + 3) tick();
    endtask

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int lat,
                        output logic ack2, output logic [31:0] dat2);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr;  bus.wbs_sel_i = sel;  bus.wbs_dat_i = wdata;
        lat = -1; rdata = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.wbs_ack_o === 1'b1) begin
                lat = i; rdata = bus.wbs_dat_o;
                break;
            end
        end
        bus_idle();
        tick();
        ack2 = bus.wbs_ack_o; dat2 = bus.wbs_dat_o;
    endtask

    task automatic do_write(input logic [7:0] ofs, input logic [31:0] d);
        logic [31:0] r, d2; int l; logic a2;
        xfer(1'b1, BASE | {24'h0, ofs}, 4'hF, d, r, l, a2, d2);
        m_write(ofs, 4'hF, d);
    endtask

    task automatic do_read(input logic [7:0] ofs, output logic [31:0] r);
        logic [31:0] d2; int l; logic a2;
        xfer(1'b0, BASE | {24'h0, ofs}, 4'hF, 32'h0, r, l, a2, d2);
    endtask

    task automatic xfer8(input logic we, input logic [7:0] ofs, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat);
        bus8.wbs_cyc_i = 1'b1; bus8.wbs_stb_i = 1'b1; bus8.wbs_we_i = we;
        bus8.wbs_adr_i = BASE | {24'h0, ofs}; bus8.wbs_sel_i = 4'hF; bus8.wbs_dat_i = wdata;
        lat = -1; rdata = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus8.wbs_ack_o === 1'b1) begin
                lat = i; rdata = bus8.wbs_dat_o;
                break;
            end
        end
        bus8.wbs_cyc_i = 1'b0; bus8.wbs_stb_i = 1'b0; bus8.wbs_we_i = 1'b0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1; io_in = 32'h0;
        repeat (3) tick();
        total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", bus.wbs_ack_o); end
        total++; if (bus.wbs_dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h exp=0", bus.wbs_dat_o); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        total++; if (io_out !== 32'h0) begin bad++; $display("FAIL reset_io_out got=%h exp=0", io_out); end
        total++; if (io_oeb !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_io_oeb got=%h exp=ffffffff", io_oeb); end
        rst = 1'b0;
        model_reset();
        tick();
        for (int k = 0; k < 6; k++) begin
            logic [7:0] ofs;
            ofs = 8'(k * 4);
            do_read(ofs, r);
            total++;
            if (r !== m_read(ofs)) begin bad++; $display("FAIL reset_reg ofs=%h got=%h exp=%h", ofs, r, m_read(ofs)); end
        end
    endtask

    task automatic test_oeb_sel();
        logic [31:0] r, d2; int l; logic a2;
        xfer(1'b1, BASE + 32'h04, 4'b0001, 32'h0000_00FF, r, l, a2, d2);
        m_write(8'h04, 4'b0001, 32'h0000_00FF);
        do_read(8'h04, r);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL oeb_sel got=%h exp=ffffffff", r); end
    endtask

    task automatic test_dout();
        logic [31:0] r, d2; int l; logic a2;
        xfer(1'b1, BASE, 4'hF, 32'hA5A5_5A5A, r, l, a2, d2);
        m_write(8'h00, 4'hF, 32'hA5A5_5A5A);
        total++; if (l != 1) begin bad++; $display("FAIL dout_latency got=%0d exp=1", l); end
        total++; if (a2 !== 1'b0) begin bad++; $display("FAIL dout_ack_width got=%b exp=0", a2); end
        total++; if (io_out !== 32'hA5A5_5A5A) begin bad++; $display("FAIL dout_io_out got=%h exp=a5a55a5a", io_out); end
    endtask

    task automatic test_random();
        logic [31:0] r, d2, wd, exp_r, old_in, new_in;
        logic [7:0]  ofs;
        logic [3:0]  sel;
        logic        we, a2;
        int          l, pick;
        for (int n = 0; n < 60; n++) begin
            if (n % 10 == 0) begin
                old_in = io_in; new_in = $urandom;
                m_stat = m_stat | ev_bits(old_in, new_in, m_esel);
                io_in = new_in;
                settle();
            end
            pick = $urandom_range(0, 7);
            if (pick < 6) ofs = 8'(pick * 4);
            else          ofs = 8'($urandom_range(6, 63) * 4);
            we = 1'($urandom_range(0, 1)); sel = 4'($urandom_range(0, 15)); wd = $urandom;
            exp_r = m_read(ofs);
            xfer(we, BASE | {24'h0, ofs}, sel, wd, r, l, a2, d2);
            if (we) m_write(ofs, sel, wd);
            total++; if (l != 1) begin bad++; $display("FAIL rnd_latency n=%0d got=%0d exp=1", n, l); end
            if (!we) begin
                total++;
                if (r !== exp_r) begin bad++; $display("FAIL rnd_read n=%0d ofs=%h got=%h exp=%h", n, ofs, r, exp_r); end
            end
            total++; if (a2 !== 1'b0 || d2 !== 32'h0) begin bad++; $display("FAIL rnd_idle n=%0d got ack=%b dat=%h exp 0/0", n, a2, d2); end
            total++; if (irq !== (|(m_stat & m_en))) begin bad++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, irq, |(m_stat & m_en)); end
            total++; if (io_out !== m_dout || io_oeb !== m_oeb) begin
                bad++; $display("FAIL rnd_pads n=%0d got=%h/%h exp=%h/%h", n, io_out, io_oeb, m_dout, m_oeb);
            end
        end
    endtask

    task automatic test_irq_rise();
        logic [31:0] r;
        m_stat = m_stat | ev_bits(io_in, 32'h0, m_esel);
        io_in = 32'h0; settle();
        do_write(8'h14, 32'h0);
        do_write(8'h10, 32'hFFFF_FFFF);
        do_write(8'h0C, 32'h8);
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rise_pre_irq got=%b exp=0", irq); end
        io_in[3] = 1'b1;
        for (int c = 1; c <= SYNC + 2; c++) begin
            tick();
            if (c == SYNC + 1) begin
                total++; if (irq !== 1'b0) begin bad++; $display("FAIL rise_irq_early got=%b exp=0", irq); end
            end
        end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL rise_irq got=%b exp=1", irq); end
        m_stat = 32'h8;
        do_read(8'h10, r);
        total++; if (r !== 32'h8) begin bad++; $display("FAIL rise_stat got=%h exp=8", r); end
        do_write(8'h10, 32'h8);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rise_w1c_irq got=%b exp=0", irq); end
        do_read(8'h10, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL rise_w1c_stat got=%h exp=0", r); end
    endtask

    task automatic test_irq_fall();
        logic [31:0] r;
        do_write(8'h0C, 32'h20);
        do_write(8'h14, 32'h20);
        io_in[5] = 1'b1; settle();
        do_read(8'h10, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL fall_on_rise got=%h exp=0", r); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL fall_on_rise_irq got=%b exp=0", irq); end
        io_in[5] = 1'b0; settle();
        do_read(8'h10, r);
        total++; if (r !== 32'h20) begin bad++; $display("FAIL fall_stat got=%h exp=20", r); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL fall_irq got=%b exp=1", irq); end
        do_write(8'h10, 32'h20);
        io_in[5] = 1'b1; settle();
        io_in[5] = 1'b0;
        repeat (SYNC) tick();
        do_write(8'h10, 32'h20);
        m_stat = 32'h20;
        do_read(8'h10, r);
        total++; if (r !== 32'h20) begin bad++; $display("FAIL fall_set_wins got=%h exp=20", r); end
    endtask

    task automatic test_unmapped();
        logic [31:0] r, d2; int l, acks; logic a2;
        xfer(1'b0, BASE + 32'h40, 4'hF, 32'h0, r, l, a2, d2);
        total++; if (l != 1 || r !== 32'h0) begin bad++; $display("FAIL unmapped_read got lat=%0d dat=%h exp 1/0", l, r); end
        xfer(1'b1, BASE + 32'h40, 4'hF, 32'h1234_5678, r, l, a2, d2);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_adr_i = BASE + 32'h100; bus.wbs_sel_i = 4'hF; bus.wbs_dat_i = ~m_dout;
        acks = 0;
        repeat (4) begin tick(); if (bus.wbs_ack_o === 1'b1) acks++; end
        bus.wbs_stb_i = 1'b0; bus.wbs_adr_i = BASE;
        repeat (3) begin tick(); if (bus.wbs_ack_o === 1'b1) acks++; end
        bus_idle(); tick();
        total++; if (acks != 0) begin bad++; $display("FAIL unselected_ack got=%0d exp=0", acks); end
        do_read(8'h00, r);
        total++; if (r !== m_dout) begin bad++; $display("FAIL unselected_write got=%h exp=%h", r, m_dout); end
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = BASE; bus.wbs_sel_i = 4'hF;
        for (int c = 0; c < 6; c++) begin
            tick();
            exp_ack = (c % 2 == 0);
            total++;
            if (bus.wbs_ack_o !== exp_ack || bus.wbs_dat_o !== (exp_ack ? m_dout : 32'h0)) begin
                bad++;
                $display("FAIL b2b c=%0d got ack=%b dat=%h exp ack=%b dat=%h", c, bus.wbs_ack_o,
                         bus.wbs_dat_o, exp_ack, exp_ack ? m_dout : 32'h0);
            end
        end
        bus_idle(); tick();
    endtask

    task automatic test_reset_midflight();
        logic [31:0] r, d2, wd; int l; logic a2;
        wd = $urandom | 32'h1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_adr_i = BASE; bus.wbs_sel_i = 4'hF; bus.wbs_dat_i = wd;
        rst = 1'b1;
        tick();
        total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL midrst_ack got=%b exp=0", bus.wbs_ack_o); end
        bus_idle(); tick();
        rst = 1'b0;
        model_reset();
        total++; if (io_out !== 32'h0) begin bad++; $display("FAIL midrst_no_commit got=%h exp=0", io_out); end
        settle();
        m_stat = io_in;
        xfer(1'b1, BASE, 4'hF, wd, r, l, a2, d2);
        m_write(8'h00, 4'hF, wd);
        total++; if (l != 1 || io_out !== wd) begin bad++; $display("FAIL midrst_reissue got lat=%0d io_out=%h exp 1/%h", l, io_out, wd); end
    endtask

    task automatic test_reset_release();
        logic [31:0] r, p;
        p = $urandom | 32'h80;
        rst = 1'b1; io_in = p;
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        repeat (SYNC) tick();
        do_read(8'h10, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL release_early got=%h exp=0", r); end
        do_read(8'h10, r);
        m_stat = p;
        total++; if (r !== p) begin bad++; $display("FAIL release_event got=%h exp=%h", r, p); end
    endtask

    task automatic test_num_io8();
        logic [31:0] r; int l;
        total++; if (io_oeb8 !== 8'hFF) begin bad++; $display("FAIL io8_oeb_reset got=%h exp=ff", io_oeb8); end
        xfer8(1'b1, 8'h00, 32'hFFFF_FFFF, r, l);
        total++; if (l != 1 || io_out8 !== 8'hFF) begin bad++; $display("FAIL io8_dout_pad got lat=%0d pad=%h exp 1/ff", l, io_out8); end
        xfer8(1'b0, 8'h00, 32'h0, r, l);
        total++; if (r !== 32'h0000_00FF) begin bad++; $display("FAIL io8_dout_read got=%h exp=000000ff", r); end
        xfer8(1'b1, 8'h04, 32'hFFFF_FF00, r, l);
        xfer8(1'b0, 8'h04, 32'h0, r, l);
        total++; if (r !== 32'h0 || io_oeb8 !== 8'h00) begin bad++; $display("FAIL io8_oeb got=%h/%h exp=0/0", r, io_oeb8); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; io_in = 32'h0; io_in8 = 8'h0;
        bus_idle();
        bus8.wbs_cyc_i = 1'b0; bus8.wbs_stb_i = 1'b0; bus8.wbs_we_i = 1'b0;
        bus8.wbs_sel_i = 4'h0; bus8.wbs_adr_i = 32'h0; bus8.wbs_dat_i = 32'h0;
        model_reset();
        tick();
        test_reset();
        test_oeb_sel();
        test_dout();
        test_random();
        test_irq_rise();
        test_irq_fall();
        test_unmapped();
        test_back_to_back();
        test_reset_midflight();
        test_reset_release();
        test_num_io8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_gpio_ctrl.md
WB_GPIO_CTRL -- requirements
Module: wb_gpio_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_IO, default 32, meaning the pad count handled, legal range 1..32.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning the Wishbone base; bits [7:0] SHALL be zero.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning input synchroniser depth, legal range 2..3.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: wb_clk_i input 1, the clock; wb_rst_i input 1, the reset.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i: input, 1 each, Wishbone strobe, cycle and write-enable.
REQ-006 wbs_sel_i input 4, byte lanes; wbs_dat_i input 32, write data; wbs_adr_i input 32, byte address.
REQ-007 wbs_ack_o output 1, acknowledge; wbs_dat_o output 32, read data.
REQ-008 io_in input NUM_IO, pad inputs; io_out output NUM_IO, pad drive; io_oeb output NUM_IO, active-low output enable.
REQ-009 irq_o output 1, level interrupt.

Function
REQ-010 Select SHALL be wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]); unselected cycles SHALL get no ack.
REQ-011 Register map, offset wbs_adr_i[7:0]: 0x00 DOUT RW; 0x04 OEB RW; 0x08 DIN RO; 0x0C IRQ_EN RW; 0x10 IRQ_STAT W1C; 0x14 EDGE_SEL RW, 0 = rising, 1 = falling.
REQ-012 Ack FSM SHALL have states IDLE and ACK: IDLE->ACK on select, asserting wbs_ack_o for exactly one cycle; ACK->IDLE unconditionally, so ack latency is 1 cycle.
REQ-013 A request still held in the cycle after ack SHALL be treated as a new request, giving at most one ack every 2 cycles.
REQ-014 Register writes SHALL take effect on the clock edge that asserts ack, honouring wbs_sel_i per byte.
REQ-015 Bits at and above NUM_IO SHALL read 0 and ignore writes.
REQ-016 wbs_dat_o SHALL hold the registered read value during the ack cycle and be 0 at all other times.
REQ-017 Unmapped offsets SHALL be acked, read 0 and ignore writes.
REQ-018 io_out SHALL equal DOUT and io_oeb SHALL equal OEB, both registered directly with no extra logic.
REQ-019 DIN SHALL be io_in passed through a SYNC_STAGES flop chain; edge detection SHALL compare the last stage against one further delayed copy.
REQ-020 On a detected edge of the selected polarity on bit i, IRQ_STAT[i] SHALL set, regardless of IRQ_EN.
REQ-021 Writing 1 to an IRQ_STAT bit SHALL clear it, writing 0 SHALL leave it unchanged, and the same-cycle edge-set SHALL win over the clear.
REQ-022 irq_o SHALL be registered |(IRQ_STAT & IRQ_EN), giving 1 cycle latency after the status change.
REQ-023 Changing EDGE_SEL SHALL NOT by itself set status bits.
REQ-024 The edge-detect and synchroniser flops SHALL reset to 0, so an input held high at reset release SHALL produce one rising event after SYNC_STAGES+1 cycles.

Reset
REQ-025 On wb_rst_i high at a clock edge, the block SHALL reset: DOUT = 0, OEB = all ones (inputs), IRQ_EN = 0, IRQ_STAT = 0, EDGE_SEL = 0, FSM = IDLE, wbs_ack_o = 0, wbs_dat_o = 0, irq_o = 0.
REQ-026 Reset during an in-flight transaction SHALL drop ack immediately with no write committed, and the master SHALL reissue the transaction.

Verification
REQ-027 Write 0x0000_00FF to OEB+0x04 with sel = 4'b0001 after reset -> read returns 0xFFFF_FFFF, since only byte 0 is written and it was already ones.
REQ-028 Write DOUT = 0xA5A5_5A5A -> io_out = 0xA5A5_5A5A on the cycle after ack, and ack is high for exactly one cycle.
REQ-029 io_in[3] 0->1 with IRQ_EN = 0x8 -> IRQ_STAT = 0x8 at SYNC_STAGES+1 cycles, irq_o high 1 cycle later; W1C 0x8 -> irq_o low.
REQ-030 EDGE_SEL[5] = 1, pulse io_in[5] high then low -> status sets only on the fall; an edge coinciding with a W1C to the same bit leaves the bit set.
REQ-031 Read offset 0x40 -> ack with 0; access with adr = BASE_ADDR + 0x100 -> no ack within 4 cycles.
REQ-032 Parameter NUM_IO = 8 -> DOUT write 0xFFFF_FFFF reads back 0x0000_00FF.
